// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// optional 2-entry skid buffer, flush-to-bubble and saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned             DATA_W   = 128,
    parameter bit                      SKID     = 1'b1,
    parameter logic [DATA_W-1:0]       NOP_DATA = '0,
    parameter int unsigned             CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              main_vld_q, main_vld_d;
    logic              skid_vld_q, skid_vld_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic in_xfer;
    logic out_xfer;

    always_comb begin
        if (SKID) begin
            in_ready = in_ready_q & ~flush & ~reset;
        end else begin
            in_ready = (~main_vld_q | out_ready) & ~flush & ~reset;
        end
    end

    assign out_valid = main_vld_q;
    assign out_data  = main_q;
    assign occupancy = {skid_vld_q, main_vld_q & ~skid_vld_q};
    assign stall_cnt = stall_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_vld_q & out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        stall_d    = stall_q;

        if (flush) begin
            main_d     = NOP_DATA;
            skid_d     = NOP_DATA;
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (SKID) begin
            if (!main_vld_q) begin
                if (in_xfer) begin
                    main_d     = in_data;
                    main_vld_d = 1'b1;
                end
            end else if (!skid_vld_q) begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    skid_d     = in_data;
                    skid_vld_d = 1'b1;
                end else if (out_xfer) begin
                    main_d     = NOP_DATA;
                    main_vld_d = 1'b0;
                end
            end else if (out_xfer) begin
                // Skid beat moves up so ordering is preserved
                main_d     = skid_q;
                skid_d     = NOP_DATA;
                skid_vld_d = 1'b0;
            end
        end else begin
            if (in_xfer) begin
                main_d     = in_data;
                main_vld_d = 1'b1;
            end else if (out_xfer) begin
                main_d     = NOP_DATA;
                main_vld_d = 1'b0;
            end
        end

        if (!flush && main_vld_q && !out_ready && stall_q != CNT_MAX) begin
            stall_d = stall_q + 1'b1;
        end

        in_ready_d = ~skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= NOP_DATA;
            skid_q     <= NOP_DATA;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register, the generic successor to the fixed-field inter-stage registers (F/D, D/E, E/M, M/W).
- Carries one packed bundle of DATA_W bits (instr, pc, operands, ALU result, condition flags) between stages.
- Uses a valid/ready handshake, an optional 2-entry skid buffer, synchronous flush with bubble insertion, and a saturating stall counter.
- One instance sits between each pair of CPU pipeline stages.

Parameters:
DATA_W, 128, width of the packed stage bundle
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
NOP_DATA, 0, bundle value presented as a bubble (reset, flush, drained)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous flush; discards all held beats
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat this cycle
in_data  in  DATA_W  upstream bundle
out_valid  out  1  out_data holds a valid beat
out_ready  in  1  downstream accepts the beat
out_data  out  DATA_W  bundle to the next stage
occupancy  out  2  number of held beats (0..2; max 1 when SKID=0)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
Definitions
- Input transfer: in_valid & in_ready at a clock edge.
- Output transfer: out_valid & out_ready at a clock edge.

Reset (clk edge with reset=1)
- out_valid=0, out_data=NOP_DATA, occupancy=0, stall_cnt=0.
- Skid entry is invalid.
- in_ready=0 while reset is high; in_ready=1 in the first cycle after reset.
- Reset overrides flush and all transfers.

Flush (reset=0, flush=1)
- in_ready is forced 0 combinationally, so no input transfer occurs.
- At the edge, all entries are invalidated, out_data=NOP_DATA, occupancy=0.
- stall_cnt is held, not cleared.
- Any output transfer in the flush cycle is still considered consumed.

Latency and ordering
- Empty stage: a beat accepted at edge N appears on out_data with out_valid=1 after edge N (1-cycle latency).
- Beats leave in acceptance order. No loss or duplication except by flush or reset.

SKID=1 states (occupancy)
- EMPTY: input transfer -> ONE; data goes to main.
- ONE:
  - in & out -> ONE; main <= in_data.
  - in only -> TWO; skid <= in_data.
  - out only -> EMPTY; main <= NOP_DATA.
  - neither -> ONE.
- TWO: in_ready=0.
  - out -> ONE; main <= skid.
  - otherwise -> TWO.
- in_ready is a register output: 1 in EMPTY/ONE, 0 in TWO. It does not depend on out_ready in the same cycle.

SKID=0
- Single main register; occupancy is 0 or 1.
- in_ready = (~out_valid | out_ready) & ~flush & ~reset.
- Simultaneous in & out: main is replaced and out_valid stays 1.
- Out only: out_valid=0 and main <= NOP_DATA.

Data holding rules
- out_data is stable while out_valid=1 and out_ready=0.
- out_data equals NOP_DATA whenever out_valid=0.

stall_cnt
- Increments by 1 at each edge with out_valid=1 and out_ready=0.
- Saturates at 2^CNT_W-1; no wrap.
- Cleared only by reset.

Test Plan:
1. Streaming: SKID=1, reset 2 cycles, then in_valid=1 with data 1,2,3,4 and out_ready=1 throughout -> out_data 1,2,3,4 on consecutive cycles, each 1 cycle after acceptance; in_ready stays 1; occupancy stays 1; stall_cnt=0.
2. Backpressure: SKID=1, push A,B,C with out_ready=0 -> A and B accepted, occupancy=2, in_ready=0 in the cycle after B, C held upstream, out_data=A stable. Raise out_ready -> A,B,C delivered in order. stall_cnt equals the number of stalled cycles (e.g. 3).
3. Flush while full: occupancy=2 with 0xAA,0xBB, assert flush for 1 cycle with in_valid=1, data 0xCC -> in_ready=0 during flush; next cycle out_valid=0, out_data=NOP_DATA, occupancy=0, 0xCC not captured; stall_cnt unchanged.
4. Reset mid-operation: occupancy=2, stall_cnt=5, assert reset -> out_valid=0, out_data=NOP_DATA, stall_cnt=0, in_ready=0 during reset and 1 after.
5. SKID=0 bubble: accept 0x10 with out_ready=0, then pulse out_ready with in_valid=1, data 0x20 -> 0x20 replaces 0x10 the same cycle. Then in_valid=0 with out_ready=1 -> out_valid=0, out_data=NOP_DATA.
6. Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
